multicycle_rv_core: RTL
=======================

Name: multicycle_rv_core

Overview:
Parametrised multi-cycle successor to the single-cycle reduced RISC-V top. It integrates PC, sign-extender, control FSM, register file and ALU around one shared memory port that uses a req/ready handshake, so it tolerates memory wait states. The instruction set grows to ADD, SUB, ADDI, LW, SW, BEQ and BNE. Any other opcode halts the core with a trap flag. It sits at the CPU top level, and the bench or SoC provides the memory model.

Parameters:
DATA_WIDTH, 32, register/ALU/memory data width (≥32)
ADDR_WIDTH, 32, memory address width and PC width (≤ DATA_WIDTH)
RESET_PC, 0, PC value loaded on reset
REG_COUNT, 32, number of architectural registers (power of 2, ≥16; x0 hard-wired to zero)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
mem_req  output  1  memory transaction request
mem_we  output  1  1 = write (SW), 0 = read
mem_addr  output  ADDR_WIDTH  byte address
mem_wdata  output  DATA_WIDTH  store data
mem_ready  input  1  transaction completes this cycle
mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready=1
a0  output  DATA_WIDTH  live value of x10
pc  output  ADDR_WIDTH  current PC
retire  output  1  one-cycle pulse per completed instruction
retired_count  output  32  instructions retired, wraps 2^32-1 → 0
trap  output  1  sticky; illegal instruction encountered

Behaviour:
- Reset: rst=0 sampled on a rising edge forces:
  - state=FETCH, pc=RESET_PC
  - all registers=0, retired_count=0, trap=0, retire=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - a0=0 on the following cycle
- Reset mid-transaction: mem_req drops the next cycle. The memory must drop any pending transaction.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready=1, latch mem_rdata into the instruction register and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Read rs1 = instr[19:15] and rs2 = instr[24:20].
  - Form the immediate, sign-extended to DATA_WIDTH:
    - I-type: instr[31:20]
    - S-type: {instr[31:25], instr[11:7]}
    - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - Illegal opcode or funct → trap=1, go to HALT. retire does not pulse and pc is unchanged.
- EXECUTE:
  - ADD/SUB/ADDI: result = rs1 ± operand, modulo 2^DATA_WIDTH, then WRITEBACK.
  - LW/SW: address = (rs1 + imm)[ADDR_WIDTH-1:0], then MEM.
  - BEQ/BNE: if taken, pc ← pc+imm, else pc ← pc+4 (both wrap mod 2^ADDR_WIDTH). Pulse retire, go to FETCH.
- MEM:
  - mem_req=1 and mem_addr=address. SW sets mem_we=1 and mem_wdata=rs2.
  - Hold until mem_ready=1.
  - LW latches mem_rdata and goes to WRITEBACK.
  - SW sets pc ← pc+4, pulses retire, goes to FETCH.
- WRITEBACK:
  - rd = instr[11:7] ← result. Writes to x0 are discarded.
  - pc ← pc+4, pulse retire, go to FETCH.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req deasserts the cycle after ready is accepted.
  - mem_ready while mem_req=0 is ignored.
  - No back-to-back requests: at least one non-request cycle separates transactions.
- Latency with zero-wait memory (mem_ready tied 1):
  - ALU ops 4 cycles, LW 5, SW 4, branch 3.
  - Each memory wait cycle adds 1.
- retire and retired_count:
  - retire is high exactly in the cycle the instruction completes.
  - retired_count increments on that same edge.
- HALT is absorbing. Only reset leaves it, and mem_req stays 0.
- a0 reflects x10 combinationally from the register array, so a write is visible the cycle after WRITEBACK.
- rd=rs1 (e.g. ADDI x10,x10,-1) uses the old value.

Test Plan:
- Reset mid-FETCH: hold mem_ready=0, pulse rst=0 → next cycle mem_req=0, pc=RESET_PC, trap=0, retired_count=0.
- Zero-wait program:
  - Program: [0]=ADDI x10,x0,5; [4]=ADDI x10,x10,-1; [8]=BNE x10,x0,-4; [12]=0x00000000.
  - Required: final a0=0, retired_count=11, trap=1, pc=12, mem_req stays 0 afterwards.
- Wait states: same program with mem_ready asserted every 3rd request cycle → identical final state, and mem_addr stays stable during every stall.
- Load/store round trip: SW x10 (=0xDEADBEEF) to 0x100 → write seen with addr 0x100, data 0xDEADBEEF, mem_we=1. Then LW x5 from 0x100 → x5=0xDEADBEEF and the LW takes 5 cycles.
- x0 and wrap:
  - ADDI x0,x0,7 → x0 reads 0.
  - ADD x10 = 0xFFFFFFFF + 1 → a0=0.
  - Taken BEQ at pc=0 with imm=-4 → pc=0xFFFFFFFC.
- Branch timing: BEQ not taken → retire 3 cycles after request start and pc+4. Taken BEQ with imm=+16 → pc+16.

Source files
------------

// File: rtl/multicycle_rv_core_if.sv
// Shared memory port of the multi-cycle core: one request at a time,
// completed by a single-cycle ready from the memory side.
interface multicycle_rv_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_rv_core.sv
// Multi-cycle reduced RISC-V core (ADD, SUB, ADDI, LW, SW, BEQ, BNE).
// A single memory port serves both instruction fetch and data access.
// All bus outputs are registered, so every transaction starts one cycle
// after the FSM decides to issue it; this also guarantees an idle cycle
// between consecutive transactions.
module multicycle_rv_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    REG_COUNT  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_rv_core_if.master    bus,
    output logic [DATA_WIDTH-1:0]   a0,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    retire,
    output logic [31:0]             retired_count,
    output logic                    trap
);
    localparam int RIDX_W = $clog2(REG_COUNT);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ILL
    } op_t;

    function automatic logic [DATA_WIDTH-1:0] sext12(input logic [11:0] v);
        return {{(DATA_WIDTH-12){v[11]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext13(input logic [12:0] v);
        return {{(DATA_WIDTH-13){v[12]}}, v};
    endfunction

    state_t                state_q, state_d;
    op_t                   op_q, op_d, dec_op;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rs1v_q, rs1v_d, rs2v_q, rs2v_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d, dec_imm;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  trap_q, trap_d;
    logic [31:0]           retired_count_q;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

    logic [RIDX_W-1:0]     rs1_idx, rs2_idx, rd_idx;
    logic [DATA_WIDTH-1:0] sum_ri;
    logic [ADDR_WIDTH-1:0] pc_seq, pc_br;
    logic                  br_taken;

    assign rs1_idx  = instr_q[15 +: RIDX_W];
    assign rs2_idx  = instr_q[20 +: RIDX_W];
    assign rd_idx   = instr_q[7 +: RIDX_W];
    assign sum_ri   = rs1v_q + imm_q;
    assign pc_seq   = pc_q + ADDR_WIDTH'(4);
    assign pc_br    = pc_q + imm_q[ADDR_WIDTH-1:0];
    // BEQ is taken on equality, BNE on inequality.
    assign br_taken = (op_q == OP_BEQ) == (rs1v_q == rs2v_q);

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign a0            = rf_q[10];
    assign pc            = pc_q;
    assign retired_count = retired_count_q;
    assign trap          = trap_q;

    // Instruction decode and immediate formation from the instruction register.
    always_comb begin
        dec_op = OP_ILL;
        case (instr_q[6:0])
            OPC_R: begin
                if (instr_q[14:12] == 3'b000 && instr_q[31:25] == 7'b0000000)      dec_op = OP_ADD;
                else if (instr_q[14:12] == 3'b000 && instr_q[31:25] == 7'b0100000) dec_op = OP_SUB;
            end
            OPC_I:     if (instr_q[14:12] == 3'b000) dec_op = OP_ADDI;
            OPC_LOAD:  if (instr_q[14:12] == 3'b010) dec_op = OP_LW;
            OPC_STORE: if (instr_q[14:12] == 3'b010) dec_op = OP_SW;
            OPC_BR: begin
                if (instr_q[14:12] == 3'b000)      dec_op = OP_BEQ;
                else if (instr_q[14:12] == 3'b001) dec_op = OP_BNE;
            end
            default: ;
        endcase
        case (dec_op)
            OP_SW:          dec_imm = sext12({instr_q[31:25], instr_q[11:7]});
            OP_BEQ, OP_BNE: dec_imm = sext13({instr_q[31], instr_q[7], instr_q[30:25],
                                              instr_q[11:8], 1'b0});
            default:        dec_imm = sext12(instr_q[31:20]);
        endcase
    end

    // Next-state, datapath and bus decisions for the control FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        trap_d   = trap_q;
        instr_d  = instr_q;
        op_d     = op_q;
        rs1v_d   = rs1v_q;
        rs2v_d   = rs2v_q;
        imm_d    = imm_q;
        result_d = result_q;
        retire   = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (bus.mem_ready) begin
                    req_d   = 1'b0;
                    instr_d = bus.mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d   = dec_op;
                rs1v_d = rf_q[rs1_idx];
                rs2v_d = rf_q[rs2_idx];
                imm_d  = dec_imm;
                if (dec_op == OP_ILL) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_ADD:  begin result_d = rs1v_q + rs2v_q; state_d = S_WRITEBACK; end
                    OP_SUB:  begin result_d = rs1v_q - rs2v_q; state_d = S_WRITEBACK; end
                    OP_ADDI: begin result_d = sum_ri;          state_d = S_WRITEBACK; end
                    OP_LW, OP_SW: begin
                        req_d   = 1'b1;
                        we_d    = (op_q == OP_SW);
                        addr_d  = sum_ri[ADDR_WIDTH-1:0];
                        wdata_d = rs2v_q;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        pc_d    = br_taken ? pc_br : pc_seq;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (req_q && bus.mem_ready) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (op_q == OP_LW) begin
                        result_d = bus.mem_rdata;
                        state_d  = S_WRITEBACK;
                    end else begin
                        pc_d    = pc_seq;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_d    = pc_seq;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    // Control state, PC, bus registers, trap flag and retirement counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_FETCH;
            pc_q            <= RESET_PC;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            trap_q          <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            trap_q  <= trap_d;
            if (retire) retired_count_q <= retired_count_q + 32'd1;
        end
    end

    // Datapath holding registers; their contents are don't-care until written.
    always_ff @(posedge clk) begin
        instr_q  <= instr_d;
        op_q     <= op_d;
        rs1v_q   <= rs1v_d;
        rs2v_q   <= rs2v_d;
        imm_q    <= imm_d;
        result_q <= result_d;
    end

    // Architectural register file; x0 never accepts a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else if (rf_we && rd_idx != '0) begin
            rf_q[rd_idx] <= result_q;
        end
    end
endmodule
